// File: rtl/clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// clock_group_reset_sequencer: fans a group reset out to member domains with staggered release.
// Optional macro: CLOCK_GROUP_RESET_SEQ_COUNT_EN (adds reset_count output).
// Revision: 1.0
// ============================================================================
module clock_group_reset_sequencer #(
   parameter int NUM_MEMBERS    = 4,
   parameter int SYNC_STAGES    = 3,
   parameter int HOLD_CYCLES    = 4,
   parameter int STAGGER_CYCLES = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   output logic [NUM_MEMBERS-1:0] member_reset,
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
   output logic [7:0]             reset_count,
`endif
   output logic                   all_released
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RELEASE = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;

   localparam logic [CNT_W-1:0]       c_hold_last    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]       c_stagger_last = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0]       c_last_idx     = IDX_W'(NUM_MEMBERS - 1);
   localparam logic [NUM_MEMBERS-1:0] c_one          = NUM_MEMBERS'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [IDX_W-1:0]       r_idx;
   logic [NUM_MEMBERS-1:0] r_member_reset;
   logic                   r_all_released;
   logic                   r_req_ready;

   logic                   w_sync_out;
   logic                   w_accept;
   logic                   w_tick;
   logic                   w_rel_done;
   logic [IDX_W-1:0]       w_next_idx;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_accept   = req_valid && r_req_ready;
   assign w_tick     = (r_cnt == c_stagger_last);
   assign w_next_idx = r_idx + 1'b1;
   // A single member goes to RUN on the edge after its release, independent of the stagger.
   assign w_rel_done = (NUM_MEMBERS == 1) ? 1'b1 : (w_tick && (r_idx == c_last_idx));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_HOLD;
         r_cnt          <= '0;
         r_idx          <= '0;
         r_member_reset <= '1;
         r_all_released <= 1'b0;
         r_req_ready    <= 1'b0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (!w_sync_out) begin
                  if (r_cnt == c_hold_last) begin
                     r_state        <= S_RELEASE;
                     r_cnt          <= '0;
                     r_idx          <= '0;
                     r_member_reset <= r_member_reset & ~c_one;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (w_rel_done) begin
                  r_state        <= S_RUN;
                  r_cnt          <= '0;
                  r_all_released <= 1'b1;
                  r_req_ready    <= 1'b1;
               end else if (w_tick) begin
                  r_cnt          <= '0;
                  r_idx          <= w_next_idx;
                  r_member_reset <= r_member_reset & ~(c_one << w_next_idx);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RUN: begin
               // Sync chain is already clear, so HOLD counting resumes on the next edge.
               if (w_accept) begin
                  r_state        <= S_HOLD;
                  r_cnt          <= '0;
                  r_idx          <= '0;
                  r_member_reset <= '1;
                  r_all_released <= 1'b0;
                  r_req_ready    <= 1'b0;
               end
            end
            default: begin
               r_state        <= S_HOLD;
               r_cnt          <= '0;
               r_idx          <= '0;
               r_member_reset <= '1;
               r_all_released <= 1'b0;
               r_req_ready    <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
   logic [7:0] r_reset_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_reset_count <= '0;
      end else if (w_accept && (r_reset_count != 8'hFF)) begin
         r_reset_count <= r_reset_count + 8'd1;
      end
   end

   assign reset_count = r_reset_count;
`endif

   assign member_reset = r_member_reset;
   assign all_released = r_all_released;
   assign req_ready    = r_req_ready;

endmodule
`default_nettype wire

// File: tb/tb_clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_clock_group_reset_sequencer: directed and random checks against a timeline model.
// Revision: 1.0
// ============================================================================
module tb_clock_group_reset_sequencer;

   localparam int N0 = 4, SY0 = 3, H0 = 4, S0 = 8;
   localparam int N2 = 1, SY2 = 2, H2 = 1, S2 = 1;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] member_reset;
   logic       all_released;
   logic       req_valid2;
   logic       req_ready2;
   logic [0:0] member_reset2;
   logic       all_released2;
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
   logic [7:0] reset_count;
   logic [7:0] reset_count2;
`endif

   int total = 0;
   int bad   = 0;
   int cyc, base0, run0, base2, run2, cnt, acc;

   always #5 clock = ~clock;

   clock_group_reset_sequencer #(
      .NUM_MEMBERS(N0), .SYNC_STAGES(SY0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(S0)
   ) u_dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .member_reset(member_reset),
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
      .reset_count(reset_count),
`endif
      .all_released(all_released)
   );

   clock_group_reset_sequencer #(
      .NUM_MEMBERS(N2), .SYNC_STAGES(SY2), .HOLD_CYCLES(H2), .STAGGER_CYCLES(S2)
   ) u_dut2 (
      .clock(clock), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .member_reset(member_reset2),
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
      .reset_count(reset_count2),
`endif
      .all_released(all_released2)
   );

   // Edge at which the sequencer reaches RUN, given the edge of member 0's release.
   function automatic int run_of(input int b, input int n, input int s);
      return (n == 1) ? b + 1 : b + n * s;
   endfunction

   // Member i is still held until edge b + i*s.
   function automatic logic [31:0] exp_mr(input int c, input int b, input int n, input int s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = (c < b + i * s);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic init_model();
      cyc   = 0;
      base0 = SY0 + H0;
      run0  = run_of(base0, N0, S0);
      base2 = SY2 + H2;
      run2  = run_of(base2, N2, S2);
      cnt   = 0;
   endtask

   task automatic chk_reset();
      chk("rst_mr0", 32'(member_reset), 32'hF);
      chk("rst_rel0", 32'(all_released), 32'd0);
      chk("rst_rdy0", 32'(req_ready), 32'd0);
      chk("rst_mr2", 32'(member_reset2), 32'h1);
      chk("rst_rel2", 32'(all_released2), 32'd0);
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
      chk("rst_cnt", 32'(reset_count), 32'd0);
`endif
   endtask

   task automatic step(input logic rv);
      req_valid = rv;
      @(posedge clock);
      cyc++;
      if (rv && (cyc - 1 >= run0)) begin
         base0 = cyc + H0;
         run0  = run_of(base0, N0, S0);
         acc++;
         if (cnt < 255) cnt++;
      end
      #1;
      chk("mr0", 32'(member_reset), exp_mr(cyc, base0, N0, S0));
      chk("rel0", 32'(all_released), 32'(cyc >= run0));
      chk("rdy0", 32'(req_ready), 32'(cyc >= run0));
      chk("mr2", 32'(member_reset2), exp_mr(cyc, base2, N2, S2));
      chk("rel2", 32'(all_released2), 32'(cyc >= run2));
      chk("rdy2", 32'(req_ready2), 32'(cyc >= run2));
`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
      chk("cnt", 32'(reset_count), 32'(cnt));
`endif
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      #1;
      chk_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      init_model();
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_valid2 = 1'b0;
      acc        = 0;
      init_model();
      repeat (3) @(posedge clock);
      #1;
      chk_reset();

      // Power-up release timeline
      @(negedge clock);
      reset = 1'b0;
      init_model();
      repeat (50) step(1'b0);

      // Single-cycle request in RUN
      repeat (3) step(1'b0);
      step(1'b1);
      repeat (45) step(1'b0);

      // Request held high from reset deassertion
      do_reset();
      repeat (50) step(1'b1);
      repeat (40) step(1'b0);

      // Random request traffic
      repeat (600) step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);

      // Asynchronous reset in the middle of RELEASE
      do_reset();
      repeat (18) step(1'b0);
      #4;
      reset = 1'b1;
      #1;
      chk_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      init_model();
      repeat (45) step(1'b0);

`ifdef CLOCK_GROUP_RESET_SEQ_COUNT_EN
      // Saturation of the accepted-request counter
      do_reset();
      acc = 0;
      for (int k = 0; k < 12000 && acc < 260; k++) step(1'b1);
      chk("sat_budget", 32'(acc), 32'd260);
      repeat (40) step(1'b0);
      chk("sat_val", 32'(reset_count), 32'd255);
      do_reset();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
